cart_bank_ctrl: RTL and testbench

- Cartridge bank-switch controller between the 6507 cartridge bus inside the 2600 core and the 32 KB ROM dpram that the HPS download fills.
- Resolves the banking scheme from the forced scheme code, or from the ROM size when no scheme is forced.
- Tracks hotspot accesses and drives the ROM address (rom_a).
- Generates Superchip (128-byte RAM) decode strobes.

---
 rtl/cart_pkg.sv | 58 +++++
 rtl/cart_hotspot_dec.sv | 73 +++++++
 rtl/cart_bank_ctrl.sv | 139 +++++++++++++
 tb/tb_cart_bank_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared constants and helpers for the cartridge bank-switch controller.
package cart_pkg;

    // Scheme codes, as carried on force_bs and bs_active
    localparam logic [3:0] BS_NONE = 4'd0;
    localparam logic [3:0] BS_F8   = 4'd1;
    localparam logic [3:0] BS_F6   = 4'd2;
    localparam logic [3:0] BS_FE   = 4'd3;
    localparam logic [3:0] BS_E0   = 4'd4;
    localparam logic [3:0] BS_3F   = 4'd5;
    localparam logic [3:0] BS_F4   = 4'd6;

    // Power-on / reset bank selections (the last bank holds the reset vector)
    localparam logic [3:0] BANK_DEF_F8 = 4'd1;
    localparam logic [3:0] BANK_DEF_F6 = 4'd3;
    localparam logic [3:0] BANK_DEF_F4 = 4'd7;
    localparam logic [3:0] BANK_DEF_3F = 4'd0;

    localparam logic [2:0] E0_SLICE0_DEF = 3'd4;
    localparam logic [2:0] E0_SLICE1_DEF = 3'd5;
    localparam logic [2:0] E0_SLICE2_DEF = 3'd6;
    localparam logic [2:0] E0_SLICE3_FIX = 3'd7;

    // Superchip window: A12 = 1 and A11..A8 = 0; A7 splits write/read ports
    localparam logic [3:0] SC_WIN_HI = 4'h0;

    // Hotspot target selector (E0 slices; all other schemes use the bank register)
    localparam logic [1:0] TGT_SLICE0 = 2'd0;
    localparam logic [1:0] TGT_SLICE1 = 2'd1;
    localparam logic [1:0] TGT_SLICE2 = 2'd2;

    // Pick the banking scheme from the forced code or, when auto, from the ROM size
    function automatic logic [3:0] resolve_scheme(input logic [3:0] force_code,
                                                  input logic [16:0] size);
        if (force_code != BS_NONE) begin
            return force_code;
        end else begin
            case (size)
                17'd8192:  return BS_F8;
                17'd16384: return BS_F6;
                17'd32768: return BS_F4;
                default:   return BS_NONE;
            endcase
        end
    endfunction

    // Bank register value loaded at reset for a given scheme
    function automatic logic [3:0] default_bank(input logic [3:0] bs);
        case (bs)
            BS_F8:   return BANK_DEF_F8;
            BS_F6:   return BANK_DEF_F6;
            BS_F4:   return BANK_DEF_F4;
            BS_3F:   return BANK_DEF_3F;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/cart_hotspot_dec.sv
// Combinational hotspot decoder: recognises bank-switch accesses for the
// active scheme and reports which register to update and with what value.
module cart_hotspot_dec
    import cart_pkg::*;
(
    input  logic [12:0] cpu_a,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_d_lo,
    input  logic [3:0]  bs_active,
    output logic        hit,
    output logic [1:0]  tgt,
    output logic [3:0]  bank_new
);

    logic [11:0] x_s;
    assign x_s = cpu_a[11:0];

    // Decode the hotspot window of the resolved scheme
    always_comb begin
        hit      = 1'b0;
        tgt      = TGT_SLICE0;
        bank_new = 4'd0;
        case (bs_active)
            BS_F8: begin
                if (cpu_a[12] && (x_s == 12'hFF8 || x_s == 12'hFF9)) begin
                    hit      = 1'b1;
                    bank_new = {3'b000, x_s[0]};
                end else begin
                    hit = 1'b0;
                end
            end
            BS_F6: begin
                if (cpu_a[12] && x_s >= 12'hFF6 && x_s <= 12'hFF9) begin
                    hit      = 1'b1;
                    bank_new = x_s[3:0] - 4'd6;
                end else begin
                    hit = 1'b0;
                end
            end
            BS_F4: begin
                if (cpu_a[12] && x_s >= 12'hFF4 && x_s <= 12'hFFB) begin
                    hit      = 1'b1;
                    bank_new = x_s[3:0] - 4'd4;
                end else begin
                    hit = 1'b0;
                end
            end
            BS_E0: begin
                // FE0-FE7 / FE8-FEF / FF0-FF7 map to slice 0/1/2 via X[4:3]
                if (cpu_a[12] && x_s >= 12'hFE0 && x_s <= 12'hFF7) begin
                    hit      = 1'b1;
                    tgt      = x_s[4:3];
                    bank_new = {1'b0, x_s[2:0]};
                end else begin
                    hit = 1'b0;
                end
            end
            BS_3F: begin
                // Writes below the cartridge (TIA area 0x00-0x3F) select the bank
                if (!cpu_a[12] && cpu_we && x_s[11:6] == 6'd0) begin
                    hit      = 1'b1;
                    bank_new = cpu_d_lo;
                end else begin
                    hit = 1'b0;
                end
            end
            default: begin
                hit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cart_bank_ctrl.sv
// Cartridge bank-switch controller: resolves the scheme at reset, tracks
// hotspot accesses, forms the ROM address and decodes Superchip RAM strobes.
module cart_bank_ctrl
    import cart_pkg::*;
#(
    parameter int ROM_AW = 15,
    parameter int SC_AW  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_ce,
    input  logic [12:0]       cpu_a,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_d,
    input  logic [3:0]        force_bs,
    input  logic [16:0]       rom_size,
    input  logic              sc,
    output logic [ROM_AW-1:0] rom_a,
    output logic              sc_ram_we,
    output logic              sc_ram_rd,
    output logic [SC_AW-1:0]  sc_ram_a,
    output logic [3:0]        bs_active
);

    logic [3:0]  bs_r;
    logic [3:0]  bank_r;
    logic [2:0]  slice0_r;
    logic [2:0]  slice1_r;
    logic [2:0]  slice2_r;
    logic        sc_en_r;
    logic        rom_big_r;
    logic [3:0]  last_bank_r;
    logic        sc_ram_we_r;

    logic [3:0]  bs_res_s;
    logic [3:0]  last_calc_s;
    logic        hit_s;
    logic [1:0]  tgt_s;
    logic [3:0]  bank_new_s;
    logic        sc_act_s;
    logic        sc_win_s;
    logic [2:0]  slice_sel_s;
    logic [14:0] rom_a_s;

    assign bs_res_s = resolve_scheme(force_bs, rom_size);
    // rom_size/2048 - 1, kept to 4 bits so a full 32 KB image wraps to 15
    assign last_calc_s = rom_size[14:11] - 4'd1;

    cart_hotspot_dec u_hotspot_dec (
        .cpu_a     (cpu_a),
        .cpu_we    (cpu_we),
        .cpu_d_lo  (cpu_d[3:0]),
        .bs_active (bs_r),
        .hit       (hit_s),
        .tgt       (tgt_s),
        .bank_new  (bank_new_s)
    );

    // Scheme, ROM-size facts and bank registers: loaded at reset, switched by hotspots
    always_ff @(posedge clk) begin
        if (reset) begin
            bs_r        <= bs_res_s;
            bank_r      <= default_bank(bs_res_s);
            slice0_r    <= E0_SLICE0_DEF;
            slice1_r    <= E0_SLICE1_DEF;
            slice2_r    <= E0_SLICE2_DEF;
            sc_en_r     <= sc;
            rom_big_r   <= (rom_size > 17'd2048);
            last_bank_r <= last_calc_s;
        end else if (cpu_ce && hit_s) begin
            if (bs_r == BS_E0) begin
                case (tgt_s)
                    TGT_SLICE0: slice0_r <= bank_new_s[2:0];
                    TGT_SLICE1: slice1_r <= bank_new_s[2:0];
                    TGT_SLICE2: slice2_r <= bank_new_s[2:0];
                    default:    slice2_r <= slice2_r;
                endcase
            end else if (bs_r == BS_3F) begin
                bank_r <= bank_new_s & last_bank_r;
            end else begin
                bank_r <= bank_new_s;
            end
        end
    end

    assign sc_act_s = sc_en_r && (bs_r == BS_F8 || bs_r == BS_F6 || bs_r == BS_F4);
    assign sc_win_s = cpu_a[12] && (cpu_a[11:8] == SC_WIN_HI);

    // Superchip write strobe: one-cycle pulse the cycle after the write-port access
    always_ff @(posedge clk) begin
        if (reset) begin
            sc_ram_we_r <= 1'b0;
        end else begin
            sc_ram_we_r <= cpu_ce && sc_act_s && sc_win_s && !cpu_a[7];
        end
    end

    // E0 slice lookup for the 1 KB window addressed by A11..A10
    always_comb begin
        slice_sel_s = E0_SLICE3_FIX;
        case (cpu_a[11:10])
            2'd0:    slice_sel_s = slice0_r;
            2'd1:    slice_sel_s = slice1_r;
            2'd2:    slice_sel_s = slice2_r;
            default: slice_sel_s = E0_SLICE3_FIX;
        endcase
    end

    // ROM address formation for the active scheme
    always_comb begin
        rom_a_s = 15'd0;
        case (bs_r)
            BS_F8, BS_F6, BS_F4: begin
                rom_a_s = {bank_r[2:0], cpu_a[11:0]};
            end
            BS_E0: begin
                rom_a_s = {2'b00, slice_sel_s, cpu_a[9:0]};
            end
            BS_3F: begin
                if (cpu_a[11]) begin
                    rom_a_s = {last_bank_r, cpu_a[10:0]};
                end else begin
                    rom_a_s = {bank_r, cpu_a[10:0]};
                end
            end
            default: begin
                // 2 KB images mirror across the 4 KB cartridge window
                rom_a_s = {3'b000, cpu_a[11] & rom_big_r, cpu_a[10:0]};
            end
        endcase
    end

    assign rom_a     = ROM_AW'(rom_a_s);
    assign sc_ram_we = sc_ram_we_r;
    assign sc_ram_rd = sc_act_s && sc_win_s && cpu_a[7];
    assign sc_ram_a  = cpu_a[SC_AW-1:0];
    assign bs_active = bs_r;

endmodule

// File: tb/tb_cart_bank_ctrl.sv
// Self-checking bench for cart_bank_ctrl: per-cycle vector table with a
// scoreboard queue of expected outputs.
module tb_cart_bank_ctrl;

    logic        clk;
    logic        reset;
    logic        cpu_ce;
    logic [12:0] cpu_a;
    logic        cpu_we;
    logic [7:0]  cpu_d;
    logic [3:0]  force_bs;
    logic [16:0] rom_size;
    logic        sc;
    logic [14:0] rom_a;
    logic        sc_ram_we;
    logic        sc_ram_rd;
    logic [6:0]  sc_ram_a;
    logic [3:0]  bs_active;

    cart_bank_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_ce    (cpu_ce),
        .cpu_a     (cpu_a),
        .cpu_we    (cpu_we),
        .cpu_d     (cpu_d),
        .force_bs  (force_bs),
        .rom_size  (rom_size),
        .sc        (sc),
        .rom_a     (rom_a),
        .sc_ram_we (sc_ram_we),
        .sc_ram_rd (sc_ram_rd),
        .sc_ram_a  (sc_ram_a),
        .bs_active (bs_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] M_ROM = 5'd1;
    localparam logic [4:0] M_RD  = 5'd2;
    localparam logic [4:0] M_WE  = 5'd4;
    localparam logic [4:0] M_BS  = 5'd8;
    localparam logic [4:0] M_SA  = 5'd16;

    typedef struct {
        int          idx;
        logic        rst;
        logic [3:0]  fbs;
        logic [16:0] rsz;
        logic        sc;
        logic        ce;
        logic        we;
        logic [12:0] a;
        logic [7:0]  d;
        logic [4:0]  m;
        logic [14:0] e_rom;
        logic        e_rd;
        logic        e_we;
        logic [3:0]  e_bs;
        logic [6:0]  e_sa;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    logic [3:0]  cur_fbs;
    logic [16:0] cur_rsz;
    logic        cur_sc;
    int          checks;
    int          errors;

    task automatic cfg(input logic [3:0] f, input logic [16:0] r, input logic s);
        cur_fbs = f;
        cur_rsz = r;
        cur_sc  = s;
    endtask

    task automatic row(input logic rst, input logic ce, input logic we,
                       input logic [12:0] a, input logic [7:0] d, input logic [4:0] m,
                       input logic [14:0] er, input logic erd, input logic ewe,
                       input logic [3:0] ebs, input logic [6:0] esa);
        vec_t v;
        v.idx = vecs.size(); v.rst = rst; v.fbs = cur_fbs; v.rsz = cur_rsz; v.sc = cur_sc;
        v.ce = ce; v.we = we; v.a = a; v.d = d; v.m = m;
        v.e_rom = er; v.e_rd = erd; v.e_we = ewe; v.e_bs = ebs; v.e_sa = esa;
        vecs.push_back(v);
    endtask

    task automatic rst_row();
        row(1'b1, 1'b0, 1'b0, 13'h0000, 8'h00, 5'd0, 15'h0000, 1'b0, 1'b0, 4'd0, 7'd0);
    endtask

    task automatic rd(input logic [12:0] a, input logic [14:0] er);
        row(1'b0, 1'b1, 1'b0, a, 8'h00, M_ROM | M_RD, er, 1'b0, 1'b0, 4'd0, 7'd0);
    endtask

    task automatic check_outputs();
        vec_t e;
        e = exp_q.pop_front();
        if (e.m[0]) begin
            checks++;
            if (rom_a !== e.e_rom) begin
                errors++;
                $display("FAIL rom_a row %0d: got %h expected %h", e.idx, rom_a, e.e_rom);
            end
        end
        if (e.m[1]) begin
            checks++;
            if (sc_ram_rd !== e.e_rd) begin
                errors++;
                $display("FAIL sc_ram_rd row %0d: got %b expected %b", e.idx, sc_ram_rd, e.e_rd);
            end
        end
        if (e.m[2]) begin
            checks++;
            if (sc_ram_we !== e.e_we) begin
                errors++;
                $display("FAIL sc_ram_we row %0d: got %b expected %b", e.idx, sc_ram_we, e.e_we);
            end
        end
        if (e.m[3]) begin
            checks++;
            if (bs_active !== e.e_bs) begin
                errors++;
                $display("FAIL bs_active row %0d: got %0d expected %0d", e.idx, bs_active, e.e_bs);
            end
        end
        if (e.m[4]) begin
            checks++;
            if (sc_ram_a !== e.e_sa) begin
                errors++;
                $display("FAIL sc_ram_a row %0d: got %h expected %h", e.idx, sc_ram_a, e.e_sa);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; cpu_ce = 1'b0; cpu_a = 13'h0000; cpu_we = 1'b0; cpu_d = 8'h00;
        force_bs = 4'd0; rom_size = 17'd0; sc = 1'b0;

        // F8 auto-detected from an 8 KB image
        cfg(4'd0, 17'd8192, 1'b0);
        rst_row();
        row(1'b0, 1'b1, 1'b0, 13'h1000, 8'h00, M_ROM | M_BS | M_WE, 15'h1000, 1'b0, 1'b0, 4'd1, 7'd0);
        row(1'b0, 1'b0, 1'b0, 13'h1FF8, 8'h00, M_ROM, 15'h1FF8, 1'b0, 1'b0, 4'd0, 7'd0);
        rd(13'h1000, 15'h1000);
        rd(13'h1FF8, 15'h1FF8);
        rd(13'h1000, 15'h0000);
        rd(13'h1FF9, 15'h0FF9);
        rd(13'h1234, 15'h1234);
        row(1'b0, 1'b1, 1'b1, 13'h1FF8, 8'hAA, M_ROM, 15'h1FF8, 1'b0, 1'b0, 4'd0, 7'd0);
        rd(13'h1234, 15'h0234);

        // F4 auto-detected from 32 KB, Superchip enabled
        cfg(4'd0, 17'd32768, 1'b1);
        rst_row();
        row(1'b0, 1'b1, 1'b0, 13'h1ABC, 8'h00, M_ROM | M_BS | M_WE, 15'h7ABC, 1'b0, 1'b0, 4'd6, 7'd0);
        rd(13'h1FF4, 15'h7FF4);
        rd(13'h1ABC, 15'h0ABC);
        row(1'b0, 1'b1, 1'b1, 13'h1005, 8'h55, M_ROM | M_RD | M_WE | M_SA, 15'h0005, 1'b0, 1'b0, 4'd0, 7'h05);
        row(1'b0, 1'b0, 1'b1, 13'h1005, 8'h55, M_ROM | M_WE | M_SA, 15'h0005, 1'b0, 1'b1, 4'd0, 7'h05);
        row(1'b0, 1'b0, 1'b0, 13'h1005, 8'h00, M_WE, 15'h0000, 1'b0, 1'b0, 4'd0, 7'd0);
        row(1'b0, 1'b1, 1'b0, 13'h1085, 8'h00, M_ROM | M_RD | M_SA, 15'h0085, 1'b1, 1'b0, 4'd0, 7'h05);
        rd(13'h1185, 15'h0185);

        // Same scheme without Superchip: no strobes
        cfg(4'd0, 17'd32768, 1'b0);
        rst_row();
        rd(13'h1085, 15'h7085);
        row(1'b0, 1'b1, 1'b1, 13'h1005, 8'h11, M_WE, 15'h0000, 1'b0, 1'b0, 4'd0, 7'd0);
        row(1'b0, 1'b0, 1'b0, 13'h1005, 8'h00, M_WE, 15'h0000, 1'b0, 1'b0, 4'd0, 7'd0);

        // E0 forced
        cfg(4'd4, 17'd8192, 1'b0);
        rst_row();
        row(1'b0, 1'b1, 1'b0, 13'h1010, 8'h00, M_ROM | M_BS, 15'h1010, 1'b0, 1'b0, 4'd4, 7'd0);
        rd(13'h1FE2, 15'h1FE2);
        rd(13'h1FED, 15'h1FED);
        rd(13'h1010, 15'h0810);
        rd(13'h1410, 15'h1410);
        rd(13'h1C10, 15'h1C10);
        rd(13'h1810, 15'h1810);
        rd(13'h1FF1, 15'h1FF1);
        rd(13'h1810, 15'h0410);

        // 3F forced, 8 KB image (bank mask 3)
        cfg(4'd5, 17'd8192, 1'b0);
        rst_row();
        row(1'b0, 1'b1, 1'b0, 13'h1100, 8'h00, M_ROM | M_BS, 15'h0100, 1'b0, 1'b0, 4'd5, 7'd0);
        row(1'b0, 1'b1, 1'b1, 13'h003F, 8'h07, M_ROM, 15'h003F, 1'b0, 1'b0, 4'd0, 7'd0);
        rd(13'h1100, 15'h1900);
        rd(13'h1900, 15'h1900);
        row(1'b0, 1'b1, 1'b1, 13'h0040, 8'h01, M_ROM, 15'h1840, 1'b0, 1'b0, 4'd0, 7'd0);
        rd(13'h1100, 15'h1900);
        row(1'b0, 1'b1, 1'b1, 13'h103F, 8'h00, M_ROM, 15'h183F, 1'b0, 1'b0, 4'd0, 7'd0);
        rd(13'h1100, 15'h1900);
        row(1'b0, 1'b1, 1'b0, 13'h003F, 8'h00, M_ROM, 15'h183F, 1'b0, 1'b0, 4'd0, 7'd0);
        rd(13'h1100, 15'h1900);
        row(1'b0, 1'b1, 1'b1, 13'h0000, 8'h02, M_ROM, 15'h1800, 1'b0, 1'b0, 4'd0, 7'd0);
        rd(13'h1100, 15'h1100);

        // No banking: 2 KB mirrored, then 4 KB; rom_size change needs reset
        cfg(4'd0, 17'd2048, 1'b0);
        rst_row();
        row(1'b0, 1'b1, 1'b0, 13'h1FFC, 8'h00, M_ROM | M_BS, 15'h07FC, 1'b0, 1'b0, 4'd0, 7'd0);
        rd(13'h1FF8, 15'h07F8);
        rd(13'h1FFC, 15'h07FC);
        cfg(4'd0, 17'd4096, 1'b0);
        rd(13'h1FFC, 15'h07FC);
        rst_row();
        rd(13'h1FFC, 15'h0FFC);
        rd(13'h1FF8, 15'h0FF8);
        rd(13'h1FFC, 15'h0FFC);
        cfg(4'd3, 17'd4096, 1'b0);
        rst_row();
        row(1'b0, 1'b1, 1'b0, 13'h1FFC, 8'h00, M_ROM | M_BS, 15'h0FFC, 1'b0, 1'b0, 4'd3, 7'd0);

        // F6 forced, then mid-run reset into F8 with a hotspot in the reset cycle
        cfg(4'd2, 17'd8192, 1'b0);
        rst_row();
        row(1'b0, 1'b1, 1'b0, 13'h1000, 8'h00, M_ROM | M_BS, 15'h3000, 1'b0, 1'b0, 4'd2, 7'd0);
        rd(13'h1FF6, 15'h3FF6);
        rd(13'h1000, 15'h0000);
        rd(13'h1FF8, 15'h0FF8);
        rd(13'h1000, 15'h2000);
        cfg(4'd1, 17'd8192, 1'b0);
        row(1'b1, 1'b1, 1'b0, 13'h1FF8, 8'h00, 5'd0, 15'h0000, 1'b0, 1'b0, 4'd0, 7'd0);
        row(1'b0, 1'b1, 1'b0, 13'h1000, 8'h00, M_ROM | M_BS, 15'h1000, 1'b0, 1'b0, 4'd1, 7'd0);

        // Apply each vector for one cycle; check mid-cycle, away from the edge
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset    = vecs[i].rst;
            force_bs = vecs[i].fbs;
            rom_size = vecs[i].rsz;
            sc       = vecs[i].sc;
            cpu_ce   = vecs[i].ce;
            cpu_we   = vecs[i].we;
            cpu_a    = vecs[i].a;
            cpu_d    = vecs[i].d;
            exp_q.push_back(vecs[i]);
            #2;
            check_outputs();
        end

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
